// File: rtl/auriga_mem_model.sv
// ---------------------------------------------------------------------------
// auriga_mem_model
//
// Purpose
//   Behavioural dual-port memory model for a CPU: an instruction fetch port
//   (read only) and a data port (read/write with byte enables). Both ports
//   share one DEPTH-word storage array. Each port returns its response
//   through an independent LATENCY-stage pipeline, so valid rises exactly
//   LATENCY cycles after the edge that accepted the request.
//
// Parameters
//   ADDR_W   byte-address width of both ports (default 32)
//   DATA_W   data width, multiple of 8 (default 32)
//   DEPTH    storage depth in DATA_W words (default 4096)
//   LATENCY  cycles from grant to response valid, 1..8 (default 1)
//
// Ports
//   clk_i             single clock, all state updates on the rising edge
//   arst_i            asynchronous active-high reset
//   inst_req_i        fetch request
//   inst_grnt_o       fetch accepted this cycle (combinational)
//   inst_addr_i       fetch byte address
//   inst_data_o       fetched word, 0 when inst_valid_o is low
//   inst_valid_o      one-cycle response pulse per accepted fetch
//   inst_err_o        fetch error, qualified by inst_valid_o
//   data_mem_req_i    data access request
//   data_mem_grnt_o   data request accepted this cycle (combinational)
//   data_mem_addr_i   data byte address
//   data_mem_ren_i    read qualifier
//   data_mem_wen_i    write qualifier
//   data_mem_wdata_i  write data
//   data_mem_be_i     write byte enables
//   data_mem_rdata_o  read data, 0 when data_mem_valid_o is low
//   data_mem_valid_o  one-cycle response pulse per accepted data access
//   data_mem_err_o    data error, qualified by data_mem_valid_o
//
// Configuration
//   AURIGA_MEM_STALL_EN  when defined, each port owns a 16-bit Fibonacci
//                        LFSR (taps 16,14,13,11) that randomly withholds
//                        grants; when undefined, grants follow requests.
// ---------------------------------------------------------------------------
module auriga_mem_model #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                arst_i,

  input  logic                inst_req_i,
  output logic                inst_grnt_o,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_data_o,
  output logic                inst_valid_o,
  output logic                inst_err_o,

  input  logic                data_mem_req_i,
  output logic                data_mem_grnt_o,
  input  logic [ADDR_W-1:0]   data_mem_addr_i,
  input  logic                data_mem_ren_i,
  input  logic                data_mem_wen_i,
  input  logic [DATA_W-1:0]   data_mem_wdata_i,
  input  logic [DATA_W/8-1:0] data_mem_be_i,
  output logic [DATA_W-1:0]   data_mem_rdata_o,
  output logic                data_mem_valid_o,
  output logic                data_mem_err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int MA_W  = $clog2(DEPTH);

  // DEPTH widened by one bit so the range compare never wraps when the
  // index field is exactly wide enough to address DEPTH words.
  localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  inst_idx;
  logic [IDX_W-1:0]  data_idx;
  logic [MA_W-1:0]   inst_ma;
  logic [MA_W-1:0]   data_ma;
  logic              inst_oob;
  logic              data_oob;
  logic [DATA_W-1:0] inst_rd_word;
  logic [DATA_W-1:0] data_rd_word;

  logic              inst_acc;
  logic              data_acc;
  logic              data_both;
  logic              data_none;
  logic              data_is_rd;
  logic              data_wr_commit;

  logic [DATA_W-1:0] inst_rsp_data;
  logic              inst_rsp_err;
  logic [DATA_W-1:0] data_rsp_data;
  logic              data_rsp_err;

  logic [LATENCY-1:0] inst_vld_q;
  logic [LATENCY-1:0] inst_err_q;
  logic [DATA_W-1:0]  inst_dat_q [LATENCY];
  logic [LATENCY-1:0] data_vld_q;
  logic [LATENCY-1:0] data_err_q;
  logic [DATA_W-1:0]  data_dat_q [LATENCY];

  // The byte-offset bits of both addresses are deliberately ignored; this
  // reduction just marks them as intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr_i, data_mem_addr_i};

  // Grant generation. With stalls enabled each port has its own free-running
  // LFSR, reseeded by reset so the stall pattern is repeatable after every
  // reset. Grants are always held low while reset is asserted.
`ifdef AURIGA_MEM_STALL_EN
  logic [15:0] inst_lfsr_q;
  logic [15:0] data_lfsr_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inst_lfsr_q <= 16'hACE1;
      data_lfsr_q <= 16'hBEEF;
    end else begin
      inst_lfsr_q <= {inst_lfsr_q[14:0],
                      inst_lfsr_q[15] ^ inst_lfsr_q[13] ^ inst_lfsr_q[12] ^ inst_lfsr_q[10]};
      data_lfsr_q <= {data_lfsr_q[14:0],
                      data_lfsr_q[15] ^ data_lfsr_q[13] ^ data_lfsr_q[12] ^ data_lfsr_q[10]};
    end
  end

  assign inst_grnt_o     = inst_req_i     & ~inst_lfsr_q[0] & ~arst_i;
  assign data_mem_grnt_o = data_mem_req_i & ~data_lfsr_q[0] & ~arst_i;
`else
  assign inst_grnt_o     = inst_req_i     & ~arst_i;
  assign data_mem_grnt_o = data_mem_req_i & ~arst_i;
`endif

  assign inst_acc = inst_req_i     & inst_grnt_o;
  assign data_acc = data_mem_req_i & data_mem_grnt_o;

  // Address decode: word index is the byte address without its offset bits.
  // Anything at or beyond DEPTH is flagged and never touches the array.
  assign inst_idx = inst_addr_i[ADDR_W-1:OFF_W];
  assign data_idx = data_mem_addr_i[ADDR_W-1:OFF_W];
  assign inst_ma  = inst_idx[MA_W-1:0];
  assign data_ma  = data_idx[MA_W-1:0];
  assign inst_oob = ({1'b0, inst_idx} >= DEPTH_EXT);
  assign data_oob = ({1'b0, data_idx} >= DEPTH_EXT);

  // Array read ports see the contents before any write committed on the
  // same edge, which gives read-before-write between the two ports.
  assign inst_rd_word = mem[inst_ma];
  assign data_rd_word = mem[data_ma];

  // Data access classification. A request with both qualifiers set is still
  // performed as a write but reported as an error; a request with neither
  // qualifier does nothing and is reported as an error.
  assign data_both      = data_mem_ren_i & data_mem_wen_i;
  assign data_none      = ~data_mem_ren_i & ~data_mem_wen_i;
  assign data_is_rd     = data_mem_ren_i & ~data_mem_wen_i;
  assign data_wr_commit = data_acc & data_mem_wen_i & ~data_oob;

  // Response payloads entering stage 0 of each pipeline. Writes, errors and
  // out-of-range accesses all return zero data.
  assign inst_rsp_err  = inst_oob;
  assign inst_rsp_data = inst_oob ? '0 : inst_rd_word;
  assign data_rsp_err  = data_oob | data_both | data_none;
  assign data_rsp_data = (data_is_rd & ~data_oob) ? data_rd_word : '0;

  // Storage write port. The array is intentionally left out of reset so its
  // contents survive a reset pulse; only enabled bytes are updated.
  always_ff @(posedge clk_i) begin
    if (data_wr_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_mem_be_i[b]) begin
          mem[data_ma][b*8 +: 8] <= data_mem_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Instruction response pipeline. Stage 0 captures the response on the
  // accepting edge and each later stage shifts one per cycle. Empty slots
  // carry zero data and zero error so the outputs are clean when idle, and
  // reset wipes every slot so in-flight responses are dropped.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inst_vld_q <= '0;
      inst_err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        inst_dat_q[i] <= '0;
      end
    end else begin
      inst_vld_q[0] <= inst_acc;
      inst_err_q[0] <= inst_acc & inst_rsp_err;
      inst_dat_q[0] <= inst_acc ? inst_rsp_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        inst_vld_q[i] <= inst_vld_q[i-1];
        inst_err_q[i] <= inst_err_q[i-1];
        inst_dat_q[i] <= inst_dat_q[i-1];
      end
    end
  end

  // Data response pipeline, same structure as the instruction side.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_vld_q <= '0;
      data_err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_dat_q[i] <= '0;
      end
    end else begin
      data_vld_q[0] <= data_acc;
      data_err_q[0] <= data_acc & data_rsp_err;
      data_dat_q[0] <= data_acc ? data_rsp_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        data_vld_q[i] <= data_vld_q[i-1];
        data_err_q[i] <= data_err_q[i-1];
        data_dat_q[i] <= data_dat_q[i-1];
      end
    end
  end

  assign inst_valid_o     = inst_vld_q[LATENCY-1];
  assign inst_err_o       = inst_err_q[LATENCY-1];
  assign inst_data_o      = inst_dat_q[LATENCY-1];
  assign data_mem_valid_o = data_vld_q[LATENCY-1];
  assign data_mem_err_o   = data_err_q[LATENCY-1];
  assign data_mem_rdata_o = data_dat_q[LATENCY-1];

endmodule

// File: doc/auriga_mem_model.md
AURIGA_MEM_MODEL -- requirements
Module: auriga_mem_model

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of both ports.
REQ-002 Parameter DATA_W, default 32: data width, multiple of 8.
REQ-003 Parameter DEPTH, default 4096: storage depth in DATA_W words.
REQ-004 Parameter LATENCY, default 1, legal range 1..8: cycles from grant to response valid.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 arst_i  in  1  reset, asynchronous assert, active-high.
REQ-007 inst_req_i  in  1  instruction fetch request.
REQ-008 inst_grnt_o  out  1  fetch request accepted this cycle.
REQ-009 inst_addr_i  in  ADDR_W  fetch byte address.
REQ-010 inst_data_o  out  DATA_W  fetched word.
REQ-011 inst_valid_o  out  1  inst_data_o valid, one-cycle pulse per granted fetch.
REQ-012 data_mem_req_i  in  1  data access request.
REQ-013 data_mem_grnt_o  out  1  data request accepted this cycle.
REQ-014 data_mem_addr_i  in  ADDR_W  data byte address.
REQ-015 data_mem_ren_i / data_mem_wen_i  in  1 each  read / write qualifier.
REQ-016 data_mem_wdata_i  in  DATA_W  write data.
REQ-017 data_mem_be_i  in  DATA_W/8  write byte enables.
REQ-018 data_mem_rdata_o  out  DATA_W  read data.
REQ-019 data_mem_valid_o  out  1  response pulse for each granted data access.
REQ-020 inst_err_o / data_mem_err_o  out  1 each  error flag, qualified by the matching valid.

Function
REQ-021 Both ports share one DEPTH-word array; word index = addr[ADDR_W-1:log2(DATA_W/8)], low bits ignored.
REQ-022 Grant is combinational from req (and stall state when configured); a request is accepted when req and grnt are both high.
REQ-023 Each port has an independent LATENCY-stage response pipeline; valid asserts exactly LATENCY cycles after the accepting edge.
REQ-024 One new request per port per cycle; back-to-back accepted requests yield back-to-back valid pulses in order.
REQ-025 Read data is sampled from the array at the accepting edge and carried through the pipeline.
REQ-026 Write commits at the accepting edge, only bytes with be=1; write response has valid=1, rdata=0.
REQ-027 Same-edge inst read and data write to the same word: inst read returns pre-write data.
REQ-028 Word index >= DEPTH: no array access, response rdata=0, err=1.
REQ-029 ren=1 and wen=1 together: treated as write, err=1; ren=0 and wen=0 with req: no access, response with err=1.
REQ-030 inst_data_o, data_mem_rdata_o are 0 whenever their valid is 0.

Reset
REQ-031 arst_i high clears all pipeline stages immediately: all valid, err, data outputs 0; grants 0 while arst_i high.
REQ-032 Array contents are not cleared by reset; in-flight responses at reset are discarded, never emitted.
REQ-033 First request can be accepted on the first rising edge after arst_i deasserts.

Configuration
REQ-034 Macro AURIGA_MEM_STALL_EN defined: each port has a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seeds 0xACE1 (inst) and 0xBEEF (data), advancing every cycle; grnt = req & ~lfsr[0].
REQ-035 AURIGA_MEM_STALL_EN undefined: no LFSR logic, grnt = req & ~arst_i on both ports.

Verification
REQ-036 Write 0xDEADBEEF to 0x10 be=4'hF, then data read 0x10 -> data_mem_valid_o LATENCY cycles after grant, rdata 0xDEADBEEF, err 0.
REQ-037 Write 0x000000AA be=4'b0001 over 0x11223344 at 0x20 -> subsequent read returns 0x112233AA.
REQ-038 LATENCY=3, fetches 0x0,0x4,0x8 on consecutive cycles -> three consecutive inst_valid_o pulses starting 3 cycles after first grant, data in order.
REQ-039 Same-cycle fetch and write 0x55555555 to 0x40 holding 0x0 -> inst_data_o 0x0; later fetch returns 0x55555555.
REQ-040 Read at DEPTH*4 and ren=wen=1 access -> valid with err=1, rdata 0; array unchanged at 0x0.
REQ-041 Assert arst_i one cycle after a granted read with LATENCY=2 -> no valid pulse; prior array contents readable after reset; with AURIGA_MEM_STALL_EN, grant pattern repeats identically after each reset.
